float_accumulator: RTL and testbench
====================================

FLOAT_ACCUMULATOR -- requirements
Module: float_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the term-counter width.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  input term present.
REQ-005 SHALL have port in_ready  output  1  block can accept a term.
REQ-006 SHALL have port in_data  input  16  half-precision term {sign, exp[4:0], fra[9:0]}.
REQ-007 SHALL have port in_last  input  1  marks the final term of a sum.
REQ-008 SHALL have port add_a  output  16  adder operand 1 (running sum), wired to float_adder num1.
REQ-009 SHALL have port add_b  output  16  adder operand 2 (registered term), wired to float_adder num2.
REQ-010 SHALL have port add_res  input  16  float_adder result.
REQ-011 SHALL have port add_ovf  input  1  float_adder overflow flag.
REQ-012 SHALL have port add_nan  input  1  float_adder nan flag.
REQ-013 SHALL have port out_valid  output  1  completed sum available.
REQ-014 SHALL have port out_ready  input  1  consumer takes the sum.
REQ-015 SHALL have port out_data  output  16  final sum.
REQ-016 SHALL have port out_ovf  output  1  sticky overflow over the sum.
REQ-017 SHALL have port out_nan  output  1  sticky nan over the sum.
REQ-018 SHALL have port out_zero  output  1  final sum has exp==0 and fra==0.
REQ-019 SHALL have port out_count  output  CNT_W  number of terms in the sum.

Function
REQ-020 SHALL implement states IDLE, ACCUM, ADD and DONE.
REQ-021 SHALL drive in_ready=1 in IDLE and ACCUM and 0 in ADD and DONE; acceptance occurs when in_valid&&in_ready at a clock edge.
REQ-022 SHALL load the accumulator with in_data and set count=1 on acceptance in IDLE; it SHALL set nan if exp==5'h1F and fra!=0, and ovf if exp==5'h1F and fra==0.
REQ-023 SHALL register in_data into add_b and in_last into last_q on acceptance in ACCUM, then move to ADD.
REQ-024 SHALL hold add_a equal to the accumulator register at all times.
REQ-025 SHALL, in ADD (exactly one cycle), capture add_res into the accumulator and OR add_ovf and add_nan into the sticky flags.
REQ-026 SHALL increment the count in ADD, saturating at 2^CNT_W-1.
REQ-027 SHALL go to DONE after an accepted IDLE term with in_last=1, or after ADD with last_q=1; otherwise it SHALL go to ACCUM.
REQ-028 SHALL give single-term latency of 1 edge and per-added-term latency of 2 edges, from acceptance to the state update.
REQ-029 SHALL assert out_valid only in DONE, holding out_data, flags and out_count stable until out_valid&&out_ready.
REQ-030 SHALL, on the DONE handshake, clear the accumulator, count and sticky flags and return to IDLE; in_ready is not asserted in that same cycle.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, accumulator, add_b, count and sticky flags to 0, and out_valid=0; in_ready SHALL read 1 once rst_n=1.
REQ-032 SHALL discard any in-progress sum when reset is asserted mid-operation, in any state, with no output produced.

Configuration
REQ-033 SHALL, when FLOAT_ACC_ABORT_EN is defined, add input port abort (1 bit): abort=1 at an edge returns to IDLE and clears all state as a synchronous clear; abort has priority over every handshake, and no term is accepted in that cycle.
REQ-034 SHALL, when FLOAT_ACC_ABORT_EN is undefined, have no abort port and behave identically to a build with abort tied to 0.

Verification
REQ-035 SHALL cover: terms 0x3C00 then 0x4000 (in_last on the 2nd) -> out_data 0x4200, out_count 2, all flags 0, out_valid 3 edges after the first acceptance.
REQ-036 SHALL cover: single term 0x4500 with in_last -> out_valid one edge later, out_data 0x4500, out_count 1.
REQ-037 SHALL cover: 0x3C00 + 0xBC00 -> out_data 0x0000, out_zero 1.
REQ-038 SHALL cover: 0x7BFF + 0x7BFF -> out_ovf 1, with the flag still 1 after a further term 0x0000 is added.
REQ-039 SHALL cover: out_ready held low for 5 cycles in DONE -> out_valid and out_data stable and in_ready 0 throughout, then IDLE one edge after out_ready rises.
REQ-040 SHALL cover: rst_n pulsed low during ADD (and abort pulsed during ACCUM when enabled) -> out_valid 0, count 0, next sum correct.

Source files
------------

// File: rtl/float_accumulator_if.sv
// Handshake and adder-side bundle for the half-precision accumulator.
// master = term producer / result consumer / adder, slave = accumulator.
interface float_accumulator_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_res;
    logic             add_ovf;
    logic             add_nan;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             out_ovf;
    logic             out_nan;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        output add_res, add_ovf, add_nan,
        input  in_ready, add_a, add_b, out_valid,
        input  out_data, out_ovf, out_nan, out_zero, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        input  add_res, add_ovf, add_nan,
        output in_ready, add_a, add_b, out_valid,
        output out_data, out_ovf, out_nan, out_zero, out_count
    );
endinterface

// File: rtl/float_accumulator.sv
// Sums a stream of fp16 terms through an external float adder.
// Optional FLOAT_ACC_ABORT_EN adds a synchronous abort input.
module float_accumulator #(
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
`ifdef FLOAT_ACC_ABORT_EN
    input logic abort,
`endif
    float_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [15:0]      acc;
    logic [15:0]      term;
    logic             last_q;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             nan;
    logic             clr;
    logic             take;
    logic             drain;
    logic             special;

`ifdef FLOAT_ACC_ABORT_EN
    assign clr = abort;
`else
    assign clr = 1'b0;
`endif

    assign take    = bus.in_valid && bus.in_ready && !clr;
    assign drain   = bus.out_valid && bus.out_ready && !clr;
    assign special = &bus.in_data[14:10];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state selection; clear overrides every handshake
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (take) state_nx = bus.in_last ? DONE : ACCUM;
                ACCUM:   if (take) state_nx = ADD;
                ADD:     state_nx = last_q ? DONE : ACCUM;
                DONE:    if (drain) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE) || (state == ACCUM);
        bus.out_valid = (state == DONE);
    end

    // accumulator, pending term, term count and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            term   <= '0;
            last_q <= 1'b0;
            count  <= '0;
            ovf    <= 1'b0;
            nan    <= 1'b0;
        end else if (clr) begin
            acc    <= '0;
            term   <= '0;
            last_q <= 1'b0;
            count  <= '0;
            ovf    <= 1'b0;
            nan    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        acc   <= bus.in_data;
                        count <= CNT_W'(1);
                        nan   <= special && (|bus.in_data[9:0]);
                        ovf   <= special && !(|bus.in_data[9:0]);
                    end
                end
                ACCUM: begin
                    if (take) begin
                        term   <= bus.in_data;
                        last_q <= bus.in_last;
                    end
                end
                ADD: begin
                    acc <= bus.add_res;
                    ovf <= ovf | bus.add_ovf;
                    nan <= nan | bus.add_nan;
                    if (count != {CNT_W{1'b1}}) begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (drain) begin
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                        nan   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.add_a     = acc;
    assign bus.add_b     = term;
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_nan   = nan;
    assign bus.out_zero  = ~|acc[14:0];
    assign bus.out_count = count;
endmodule

// File: tb/tb_float_accumulator.sv
// Randomised bench for float_accumulator with an fp16 adder stub.
// Expected sums come from a real-arithmetic model of the term stream.
module tb_float_accumulator;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef FLOAT_ACC_ABORT_EN
    logic abort = 1'b0;
`endif

    float_accumulator_if #(.CNT_W(CNT_W)) bus ();

    float_accumulator #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FLOAT_ACC_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] d;
        logic        ovf;
        logic        nan;
        logic        zero;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] terms[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    bit          rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  f = int'(h[9:0]);
        real v;
        if (e == 0) v = f * pow2(-24);
        else v = (1024 + f) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic int rne(input real x);
        int  i = $rtoi(x);
        real r = x - i;
        if (r > 0.5 || (r == 0.5 && (i % 2) == 1)) i++;
        return i;
    endfunction

    function automatic logic [15:0] r2h(input real v, output logic ovf);
        logic s;
        real  a;
        real  m;
        int   e;
        int   f;
        ovf = 1'b0;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a < pow2(-14)) begin
            f = rne(a * pow2(24));
            return {s, 15'(f)};
        end
        e = -14;
        m = a * pow2(14);
        while (m >= 2.0) begin
            m = m / 2.0;
            e++;
        end
        f = rne(m * 1024.0);
        if (f == 2048) begin
            f = 1024;
            e++;
        end
        if (e + 15 >= 31) begin
            ovf = 1'b1;
            return {s, 5'h1F, 10'h000};
        end
        return {s, 5'(e + 15), 10'(f - 1024)};
    endfunction

    // returns {ovf, nan, result}
    function automatic logic [17:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic        na = (&a[14:10]) && (|a[9:0]);
        logic        nb = (&b[14:10]) && (|b[9:0]);
        logic        ia = (&a[14:10]) && !(|a[9:0]);
        logic        ib = (&b[14:10]) && !(|b[9:0]);
        logic        o;
        logic [15:0] r;
        if (na || nb) return {2'b01, 16'h7E00};
        if (ia && ib && (a[15] != b[15])) return {2'b01, 16'h7E00};
        if (ia) return {2'b10, a};
        if (ib) return {2'b10, b};
        r = r2h(h2r(a) + h2r(b), o);
        return {o, 1'b0, r};
    endfunction

    // the adder the accumulator is wired to
    always_comb begin
        {bus.add_ovf, bus.add_nan, bus.add_res} = fp16_add(bus.add_a, bus.add_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void build_exp();
        exp_t        e;
        logic [17:0] r;
        e.d   = terms[0];
        e.nan = (&terms[0][14:10]) && (|terms[0][9:0]);
        e.ovf = (&terms[0][14:10]) && !(|terms[0][9:0]);
        for (int i = 1; i < terms.size(); i++) begin
            r     = fp16_add(e.d, terms[i]);
            e.d   = r[15:0];
            e.ovf = e.ovf | r[17];
            e.nan = e.nan | r[16];
        end
        e.zero = (e.d[14:0] == 15'd0);
        e.cnt  = (terms.size() > CMAX) ? CMAX : terms.size();
        exp_q.push_back(e);
    endfunction

    // compare process: every cycle a sum is presented
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                check("sum",
                      {5'd0, bus.out_data, bus.out_ovf, bus.out_nan,
                       bus.out_zero, bus.out_count},
                      {5'd0, exp_q[0].d, exp_q[0].ovf, exp_q[0].nan,
                       exp_q[0].zero, CNT_W'(exp_q[0].cnt)});
                check("in_ready_done", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [15:0] d, input logic l, output int t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            t = cyc;
            return;
        end
        @(posedge clk);
        #1;
        t            = cyc;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        terms.push_back(d);
        if (l) begin
            build_exp();
            terms.delete();
        end
    endtask

    task automatic wait_valid(output int t);
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.out_valid) check("valid_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic drain_all();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            n++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_term();
        logic [4:0] e;
        if ($urandom_range(0, 15) == 0) e = 5'h1F;
        else if ($urandom_range(0, 1) == 1) e = 5'($urandom_range(12, 18));
        else e = 5'($urandom_range(0, 30));
        return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
    endfunction

    initial begin
        int t0;
        int t1;
        int tv;
        int k;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.out_count), 32'd0);
        check("rst_acc", 32'(bus.out_data), 32'd0);
        check("rst_add_b", 32'(bus.add_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // hand-computed pins on the model itself
        check("model_1p2", 32'(fp16_add(16'h3C00, 16'h4000)), 32'h04200);
        check("model_cancel", 32'(fp16_add(16'h3C00, 16'hBC00)), 32'h00000);
        check("model_ovf", 32'(fp16_add(16'h7BFF, 16'h7BFF)), 32'h27C00);
        check("model_half", 32'(fp16_add(16'h3800, 16'h3800)), 32'h03C00);

        @(posedge clk);
        #1;
        // 1.0 + 2.0
        send(16'h3C00, 1'b0, t0);
        send(16'h4000, 1'b1, t1);
        wait_valid(tv);
        check("two_term_latency", 32'(tv - t0 + 1), 32'd3);
        check("two_term_data", 32'(bus.out_data), 32'h4200);
        check("two_term_count", 32'(bus.out_count), 32'd2);
        check("two_term_flags",
              {29'd0, bus.out_ovf, bus.out_nan, bus.out_zero}, 32'd0);
        drain_all();

        // single term
        send(16'h4500, 1'b1, t0);
        wait_valid(tv);
        check("single_latency", 32'(tv - t0 + 1), 32'd1);
        check("single_data", 32'(bus.out_data), 32'h4500);
        check("single_count", 32'(bus.out_count), 32'd1);
        drain_all();

        // cancellation to zero
        send(16'h3C00, 1'b0, t0);
        send(16'hBC00, 1'b1, t0);
        wait_valid(tv);
        check("cancel_data", 32'(bus.out_data), 32'h0000);
        check("cancel_zero", 32'(bus.out_zero), 32'd1);
        drain_all();

        // overflow stays sticky across a further term
        send(16'h7BFF, 1'b0, t0);
        send(16'h7BFF, 1'b0, t0);
        send(16'h0000, 1'b1, t0);
        wait_valid(tv);
        check("ovf_sticky", 32'(bus.out_ovf), 32'd1);
        check("ovf_count", 32'(bus.out_count), 32'd3);
        drain_all();

        // consumer back-pressure in DONE
        bus.out_ready = 1'b0;
        send(16'h4500, 1'b1, t0);
        wait_valid(tv);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'h4500);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        drain_all();

        // reset during ADD discards the sum
        send(16'h3C00, 1'b0, t0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4000;
        bus.in_last  = 1'b1;
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        terms.delete();
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_count", 32'(bus.out_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'h3C00, 1'b0, t0);
        send(16'h3C00, 1'b1, t0);
        wait_valid(tv);
        check("postrst_data", 32'(bus.out_data), 32'h4000);
        check("postrst_count", 32'(bus.out_count), 32'd2);
        drain_all();

`ifdef FLOAT_ACC_ABORT_EN
        // abort during ACCUM wins over the offered term
        send(16'h3C00, 1'b0, t0);
        abort        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4000;
        bus.in_last  = 1'b1;
        @(posedge clk);
        #1;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        terms.delete();
        @(negedge clk);
        check("abort_count", 32'(bus.out_count), 32'd0);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(16'h4400, 1'b1, t0);
        wait_valid(tv);
        check("abort_next_data", 32'(bus.out_data), 32'h4400);
        check("abort_next_count", 32'(bus.out_count), 32'd1);
        drain_all();
`endif

        // random sums with random gaps and back-pressure
        rand_rdy = 1'b1;
        for (int s = 0; s < 40; s++) begin
            k = $urandom_range(1, 5);
            for (int j = 0; j < k; j++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(rand_term(), 1'(j == k - 1), t0);
            end
        end

        // count saturation
        for (int j = 0; j < 300; j++) begin
            send(16'h0000, 1'(j == 299), t0);
        end
        drain_all();
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
